// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared FSM encodings, defaults and width helpers for the instruction cache
package icache_pkg;

  localparam int XLEN      = 32;
  localparam int LINES_DEF = 16;
  localparam int WORDS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  // Tag width left over after byte, word and index fields of a 32-bit address
  function automatic int tag_bits(input int lines, input int words);
    return XLEN - 2 - $clog2(words) - $clog2(lines);
  endfunction

endpackage

// File: rtl/icache_if.sv
// rtl/icache_if.sv - fetch-side and refill-side signal bundle of the instruction cache
interface icache_if;

  logic [31:0] PCF;
  logic        FetchEn;
  logic        InvalidateAll;
  logic [31:0] InstrF;
  logic        MissStallF;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemReady;
  logic [31:0] MemRData;

  // Cache side
  modport slave (
    input  PCF, FetchEn, InvalidateAll, MemReady, MemRData,
    output InstrF, MissStallF, MemReq, MemAddr
  );

  // Fetch stage plus backing memory side
  modport master (
    output PCF, FetchEn, InvalidateAll, MemReady, MemRData,
    input  InstrF, MissStallF, MemReq, MemAddr
  );

endinterface

// File: rtl/icache_line_ram.sv
// rtl/icache_line_ram.sv - data/tag/valid arrays: async read, single-word write, bulk valid clear
module icache_line_ram
  import icache_pkg::*;
#(
  parameter int LINES = LINES_DEF,
  parameter int WORDS = WORDS_DEF,
  parameter int IW    = 4,
  parameter int WW    = 2,
  parameter int TW    = 24
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IW-1:0]   rd_idx_i,
  input  logic [WW-1:0]   rd_word_i,
  output logic [XLEN-1:0] rd_data_o,
  output logic [TW-1:0]   rd_tag_o,
  output logic            rd_valid_o,
  input  logic            we_i,
  input  logic [IW-1:0]   wr_idx_i,
  input  logic [WW-1:0]   wr_word_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            tag_we_i,
  input  logic [TW-1:0]   wtag_i,
  input  logic            set_valid_i,
  input  logic            clear_all_i
);

  logic [XLEN-1:0]  data_q [LINES][WORDS];
  logic [TW-1:0]    tag_q  [LINES];
  logic [LINES-1:0] valid_q;

  assign rd_data_o  = data_q[rd_idx_i][rd_word_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];

  // Refill beats land one word at a time; contents survive reset
  always_ff @(posedge clk) begin
    if (we_i) data_q[wr_idx_i][wr_word_i] <= wdata_i;
  end

  // Tag is written once per fill, when the line is committed
  always_ff @(posedge clk) begin
    if (tag_we_i) tag_q[wr_idx_i] <= wtag_i;
  end

  // Valid bits: clear-all wins over a same-cycle set
  always_ff @(posedge clk) begin
    if (reset || clear_all_i) valid_q <= '0;
    else if (set_valid_i)     valid_q[wr_idx_i] <= 1'b1;
  end

endmodule

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped instruction cache top; ICACHE_STATS_EN adds hit/miss counters
module icache
  import icache_pkg::*;
#(
  parameter int LINES = LINES_DEF,
  parameter int WORDS = WORDS_DEF
) (
  input  logic     clk,
  input  logic     reset,
  icache_if.slave  bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] HitCount,
  output logic [31:0] MissCount
`endif
);

  localparam int WW = $clog2(WORDS);
  localparam int IW = $clog2(LINES);
  localparam int TW = tag_bits(LINES, WORDS);
  localparam int LW = TW + IW;

  state_e          state_q;
  logic [WW-1:0]   beat_q;
  logic [WW-1:0]   beat_nx;
  logic [LW-1:0]   line_q;
  logic            pend_q;
  logic            mem_req_q;
  logic [31:0]     mem_addr_q;

  logic [TW-1:0]   pc_tag;
  logic [IW-1:0]   pc_idx;
  logic [WW-1:0]   pc_word;
  logic [31:0]     rd_data;
  logic [TW-1:0]   rd_tag;
  logic            rd_valid;
  logic            hit;
  logic            idle;
  logic            ram_we;
  logic            commit;
  logic            set_valid;
  logic            unused_pc_lo;

  assign pc_word      = bus.PCF[2 +: WW];
  assign pc_idx       = bus.PCF[2 + WW +: IW];
  assign pc_tag       = bus.PCF[31 -: TW];
  assign unused_pc_lo = ^bus.PCF[1:0];
  assign beat_nx      = beat_q + WW'(1);

  assign idle = (state_q == IDLE);
  assign hit  = rd_valid && (rd_tag == pc_tag);

  assign bus.InstrF     = (!reset && idle && hit) ? rd_data : 32'h0;
  assign bus.MissStallF = !reset && bus.FetchEn && (!hit || !idle);
  assign bus.MemReq     = mem_req_q;
  assign bus.MemAddr    = mem_addr_q;

  assign ram_we    = !reset && (state_q == FILL) && bus.MemReady;
  assign commit    = !reset && (state_q == COMMIT);
  assign set_valid = commit && !pend_q && !bus.InvalidateAll;

  icache_line_ram #(
    .LINES(LINES), .WORDS(WORDS), .IW(IW), .WW(WW), .TW(TW)
  ) u_ram (
    .clk         (clk),
    .reset       (reset),
    .rd_idx_i    (pc_idx),
    .rd_word_i   (pc_word),
    .rd_data_o   (rd_data),
    .rd_tag_o    (rd_tag),
    .rd_valid_o  (rd_valid),
    .we_i        (ram_we),
    .wr_idx_i    (line_q[IW-1:0]),
    .wr_word_i   (beat_q),
    .wdata_i     (bus.MemRData),
    .tag_we_i    (commit),
    .wtag_i      (line_q[LW-1:IW]),
    .set_valid_i (set_valid),
    .clear_all_i (bus.InvalidateAll)
  );

  // Miss FSM: latch the line, stream beats in order, then commit tag/valid
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      line_q     <= '0;
      pend_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.FetchEn && !hit) begin
            state_q    <= FILL;
            line_q     <= {pc_tag, pc_idx};
            beat_q     <= '0;
            pend_q     <= 1'b0;
            mem_req_q  <= 1'b1;
            mem_addr_q <= {pc_tag, pc_idx, {WW{1'b0}}, 2'b00};
          end
        end
        FILL: begin
          if (bus.InvalidateAll) pend_q <= 1'b1;
          if (bus.MemReady) begin
            beat_q <= beat_nx;
            if (beat_q == WW'(WORDS - 1)) begin
              state_q    <= COMMIT;
              mem_req_q  <= 1'b0;
              mem_addr_q <= '0;
            end else begin
              mem_addr_q <= {line_q, beat_nx, 2'b00};
            end
          end
        end
        COMMIT: begin
          state_q <= IDLE;
          pend_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  // Fetch statistics: hits served from IDLE and fills started
  always_ff @(posedge clk) begin
    if (reset) begin
      HitCount  <= '0;
      MissCount <= '0;
    end else begin
      if (idle && bus.FetchEn && hit)  HitCount  <= HitCount + 32'd1;
      if (idle && bus.FetchEn && !hit) MissCount <= MissCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - directed table-driven bench for the instruction cache
module tb_icache;

  typedef struct {
    logic        fetch;
    logic [31:0] pc;
    logic        inv;
    logic        rdy;
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    int          hit_ev;
    int          miss_ev;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   exp_hits = 0;
  int   exp_miss = 0;
  vec_t tv[$];

  always #5 clk = ~clk;

  icache_if bus();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache #(.LINES(16), .WORDS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ICACHE_STATS_EN
    ,
    .HitCount  (hit_count),
    .MissCount (miss_count)
`endif
  );

  // Backing memory: every word is a fixed scramble of its own address
  function automatic logic [31:0] md(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign bus.MemRData = md(bus.MemAddr);

  function automatic vec_t mk(input logic f, input logic [31:0] pc, input logic inv, input logic rdy,
                              input logic st, input logic rq, input logic [31:0] ad,
                              input logic [31:0] ins, input int h, input int m);
    vec_t v;
    v.fetch = f; v.pc = pc; v.inv = inv; v.rdy = rdy;
    v.stall = st; v.req = rq; v.addr = ad; v.instr = ins;
    v.hit_ev = h; v.miss_ev = m;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic [31:0] pc, input logic inv, input logic rdy);
    @(posedge clk);
    #1;
    bus.FetchEn       = f;
    bus.PCF           = pc;
    bus.InvalidateAll = inv;
    bus.MemReady      = rdy;
    @(negedge clk);
  endtask

  task automatic ev(input int h, input int m);
    exp_hits += h;
    exp_miss += m;
  endtask

  // Keep clocking with current inputs until the stall drops, then expect the hit data
  task automatic wait_done(input string name, input logic [31:0] exp_instr);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (bus.MissStallF && n < 40);
    checks++;
    if (bus.MissStallF) begin
      errors++;
      $display("FAIL %s: stall still 1 after %0d cycles, expected 0", name, n);
    end else begin
      ev(1, 0);
    end
    chk({name, " instr"}, bus.InstrF, exp_instr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    // Cold miss, hits, fetch-off idle, conflict refill, redirect during fill
    tv.push_back(mk(1, 32'h40, 0, 1,  1, 0, 32'h0, 32'h0, 0, 1));
    for (int b = 0; b < 4; b++) tv.push_back(mk(1, 32'h40, 0, 1,  1, 1, 32'h40 + 4 * b, 32'h0, 0, 0));
    tv.push_back(mk(1, 32'h40, 0, 1,  1, 0, 32'h0, 32'h0, 0, 0));
    tv.push_back(mk(1, 32'h40, 0, 1,  0, 0, 32'h0, md(32'h40), 1, 0));
    tv.push_back(mk(1, 32'h44, 0, 1,  0, 0, 32'h0, md(32'h44), 1, 0));
    tv.push_back(mk(1, 32'h4C, 0, 1,  0, 0, 32'h0, md(32'h4C), 1, 0));
    tv.push_back(mk(0, 32'h100, 0, 1, 0, 0, 32'h0, 32'h0, 0, 0));
    tv.push_back(mk(1, 32'h140, 0, 1, 1, 0, 32'h0, 32'h0, 0, 1));
    for (int b = 0; b < 4; b++) tv.push_back(mk(1, 32'h140, 0, 1, 1, 1, 32'h140 + 4 * b, 32'h0, 0, 0));
    tv.push_back(mk(1, 32'h140, 0, 1, 1, 0, 32'h0, 32'h0, 0, 0));
    tv.push_back(mk(1, 32'h140, 0, 1, 0, 0, 32'h0, md(32'h140), 1, 0));
    tv.push_back(mk(1, 32'h40, 0, 1,  1, 0, 32'h0, 32'h0, 0, 1));
    tv.push_back(mk(1, 32'h40, 0, 1,  1, 1, 32'h40, 32'h0, 0, 0));
    for (int b = 1; b < 4; b++) tv.push_back(mk(1, 32'h300, 0, 1, 1, 1, 32'h40 + 4 * b, 32'h0, 0, 0));
    tv.push_back(mk(1, 32'h300, 0, 1, 1, 0, 32'h0, 32'h0, 0, 0));
    tv.push_back(mk(1, 32'h44, 0, 1,  0, 0, 32'h0, md(32'h44), 1, 0));

    // Reset state
    reset = 1'b1;
    bus.FetchEn = 1'b1; bus.PCF = 32'h40; bus.InvalidateAll = 1'b0; bus.MemReady = 1'b1;
    @(negedge clk);
    chk("rst stall", {31'h0, bus.MissStallF}, 32'h0);
    chk("rst instr", bus.InstrF, 32'h0);
    @(negedge clk);
    chk("rst req", {31'h0, bus.MemReq}, 32'h0);
    chk("rst addr", bus.MemAddr, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.FetchEn = 1'b0;
    @(negedge clk);
    chk("idle nofetch stall", {31'h0, bus.MissStallF}, 32'h0);
    chk("idle nofetch req", {31'h0, bus.MemReq}, 32'h0);

    foreach (tv[i]) begin
      drive(tv[i].fetch, tv[i].pc, tv[i].inv, tv[i].rdy);
      chk($sformatf("v%0d stall", i), {31'h0, bus.MissStallF}, {31'h0, tv[i].stall});
      chk($sformatf("v%0d req", i), {31'h0, bus.MemReq}, {31'h0, tv[i].req});
      chk($sformatf("v%0d addr", i), bus.MemAddr, tv[i].addr);
      chk($sformatf("v%0d instr", i), bus.InstrF, tv[i].instr);
      ev(tv[i].hit_ev, tv[i].miss_ev);
    end

    // Invalidate in IDLE: this cycle still hits, the next one misses
    drive(1, 32'h48, 1, 1);
    chk("invidle hit stall", {31'h0, bus.MissStallF}, 32'h0);
    chk("invidle hit instr", bus.InstrF, md(32'h48));
    ev(1, 0);
    drive(1, 32'h48, 0, 1);
    chk("invidle miss stall", {31'h0, bus.MissStallF}, 32'h1);
    ev(0, 1);
    wait_done("invidle refill", md(32'h48));

    // Backpressure: three idle cycles before each accepted beat
    drive(1, 32'h200, 0, 0);
    chk("bp miss stall", {31'h0, bus.MissStallF}, 32'h1);
    ev(0, 1);
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 4; k++) begin
        drive(1, 32'h200, 0, (k == 3));
        chk($sformatf("bp b%0d k%0d req", b, k), {31'h0, bus.MemReq}, 32'h1);
        chk($sformatf("bp b%0d k%0d addr", b, k), bus.MemAddr, 32'h200 + 4 * b);
      end
    end
    drive(1, 32'h200, 0, 1);
    chk("bp commit req", {31'h0, bus.MemReq}, 32'h0);
    chk("bp commit stall", {31'h0, bus.MissStallF}, 32'h1);
    drive(1, 32'h20C, 0, 1);
    chk("bp hit stall", {31'h0, bus.MissStallF}, 32'h0);
    chk("bp hit instr", bus.InstrF, md(32'h20C));
    ev(1, 0);

    // Invalidate at beat 2 of the fill for 0x80
    drive(1, 32'h80, 0, 1);
    chk("invfill miss stall", {31'h0, bus.MissStallF}, 32'h1);
    ev(0, 1);
    for (int b = 0; b < 4; b++) begin
      drive(1, 32'h80, (b == 2), 1);
      chk($sformatf("invfill b%0d addr", b), bus.MemAddr, 32'h80 + 4 * b);
    end
    drive(1, 32'h80, 0, 1);
    chk("invfill commit req", {31'h0, bus.MemReq}, 32'h0);
    drive(1, 32'h80, 0, 1);
    chk("invfill remiss stall", {31'h0, bus.MissStallF}, 32'h1);
    chk("invfill remiss instr", bus.InstrF, 32'h0);
    ev(0, 1);
    wait_done("invfill refill", md(32'h80));
    drive(1, 32'h20C, 0, 1);
    chk("invfill other line stall", {31'h0, bus.MissStallF}, 32'h1);
    ev(0, 1);
    wait_done("invfill other refill", md(32'h20C));

    // Reset at beat 1 of the fill for 0xC0
    drive(1, 32'hC0, 0, 1);
    chk("rstfill miss stall", {31'h0, bus.MissStallF}, 32'h1);
    ev(0, 1);
    drive(1, 32'hC0, 0, 1);
    chk("rstfill b0 addr", bus.MemAddr, 32'hC0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rstfill b1 addr", bus.MemAddr, 32'hC4);
    chk("rstfill rst stall", {31'h0, bus.MissStallF}, 32'h0);
    chk("rstfill rst instr", bus.InstrF, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_hits = 0;
    exp_miss = 0;
    @(negedge clk);
    chk("rstfill after req", {31'h0, bus.MemReq}, 32'h0);
    chk("rstfill after addr", bus.MemAddr, 32'h0);
    chk("rstfill after stall", {31'h0, bus.MissStallF}, 32'h1);
    ev(0, 1);
    wait_done("rstfill refill", md(32'hC0));
    drive(1, 32'h80, 0, 1);
    chk("rstfill old line stall", {31'h0, bus.MissStallF}, 32'h1);
    ev(0, 1);
    wait_done("rstfill old refill", md(32'h80));

    drive(0, 32'h0, 0, 1);
`ifdef ICACHE_STATS_EN
    chk("hit count", hit_count, exp_hits);
    chk("miss count", miss_count, exp_miss);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
